act_calc_pipe: RTL and testbench
================================

// Module: act_calc_pipe
// PURPOSE
//   Parametrised, pipelined activation unit for the autoencoder datapath. Converts
//   LANES signed Q2.(DAT_W-2) pre-activations per beat into Q1.(DAT_W-1) outputs.
//   Runtime modes: tanh (1-(1-|x|)^2 approximation), sigmoid (derived from tanh) and
//   saturating ReLU. Sits between the MAC accumulator and the next layer's input
//   buffer, with full valid/ready backpressure.
// PARAMETERS
//   DAT_W   8   input and output word width, in bits (>=6)
//   LANES   1   parallel lanes per beat; all lanes share handshake and mode
//   CNT_W   16  width of the saturation event counter
// PORTS
//   clk        in   1              clock
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              input beat valid
//   in_ready   out  1              unit can accept a beat this cycle
//   in_mode    in   2              0 tanh, 1 sigmoid, 2 relu, 3 reserved; sampled with the beat
//   in_x       in   LANES*DAT_W    lane i = bits [i*DAT_W +: DAT_W], signed Q2.(DAT_W-2)
//   out_valid  out  1              output beat valid
//   out_ready  in   1              downstream accepts the beat
//   out_y      out  LANES*DAT_W    signed Q1.(DAT_W-1), same lane packing as in_x
//   out_sat    out  LANES          per-lane flag: the result was clamped
//   sat_cnt    out  CNT_W          running count of clamped lanes; sticks at all-ones
//   cnt_clr    in   1              synchronous clear of sat_cnt
// BEHAVIOUR
//   Reset: all stage valids=0, out_y=0, out_sat=0, sat_cnt=0. in_ready=1 once reset is released.
//   Pipeline: 3 register stages (S1 abs/prescale, S2 square, S3 finalise/sign).
//     Latency is 3 cycles from accepted input to out_valid when out_ready stays 1.
//   Handshake: a beat transfers when valid&ready. Global advance en = ~out_valid | out_ready.
//     in_ready = en. All stages hold their contents while en=0. out_y is stable while
//     out_valid & ~out_ready. Full throughput is 1 beat/cycle.
//   Per lane, F=DAT_W-2:
//     a = |x|; x = -2.0 (MSB-only pattern) maps to a = max positive.
//     sigmoid: a = |x|>>>1, computed as |x/2| (arithmetic shift right by 1 applied to |x|).
//     am = min(a, 1.0) in Q2.F; am >= 1.0 sets sat.
//     t = 1.0 - am (0..1, F+1 bits); s = t*t, truncated to F fraction bits.
//     m = 1.0 - s in [0,1]; convert to Q1.(DAT_W-1) by shifting left 1.
//       m == 1.0 clamps to max positive 0x7F..F and sets sat.
//     tanh:    y = x<0 ? -m : m (two's complement negate).
//     sigmoid: y = 0.5 + (x<0 ? -m : m)/2, arithmetic shift right; clamp to max positive.
//     relu:    y = x<0 ? 0 : x<<1; if x >= 1.0, clamp to max positive and set sat.
//     mode 3:  y = 0, sat = 0.
//   Mode travels with the beat through the pipe; a mode change between beats needs no flush.
//   sat_cnt increments by popcount(out_sat) on each output transfer and saturates at
//     all-ones. cnt_clr has priority over an increment in the same cycle.
//   Reset asserted mid-stream discards all in-flight beats; out_valid drops asynchronously.
// STRUCTURE
//   act_pkg: mode enum act_mode_e {ACT_TANH, ACT_SIGM, ACT_RELU, ACT_RSVD};
//     function sat_max(width) returning the max-positive constant.
//   Sub-module act_lane_core: one combinational-per-stage lane slice with stage registers.
//     Instantiated LANES times in a generate loop. The top owns handshake, valids and sat_cnt.
// TESTING (DAT_W=8, LANES=2 unless noted)
//   tanh, in_x lanes {0x20,0xE0} (+0.5,-0.5) -> 3 cycles later out_y {0x60,0xA0}, out_sat=0.
//   tanh {0x40,0x80} (1.0,-2.0) -> out_y {0x7F,0x81}, out_sat=2'b11, sat_cnt=2.
//   sigmoid {0x00,0x40} -> out_y {0x40,0x70}; relu {0x20,0xF0} -> {0x40,0x00}.
//   Stream 8 beats while out_ready toggles 1,0,0,1,...
//     -> no loss or duplication, order kept, out_y stable while stalled.
//   Mode alternates tanh/relu every beat at full rate -> each output matches its own beat's mode.
//   rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, sat_cnt=0,
//     no stale beat after release. cnt_clr together with a saturating beat -> sat_cnt=0.

Source files
------------

// File: rtl/act_pkg.sv
// Shared types and helpers for the activation pipeline.
// Mode encoding and saturation constants used by lane and top.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_TANH,
    ACT_SIGM,
    ACT_RELU,
    ACT_RSVD
  } act_mode_e;

  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/act_lane_core.sv
// One activation lane: abs/prescale, square, finalise/sign.
// Stage registers advance together on en; valids live in the top.
module act_lane_core
  import act_pkg::*;
#(
  parameter int DAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  act_mode_e        mode_i,
  input  logic [DAT_W-1:0] x_i,
  output logic [DAT_W-1:0] y_o,
  output logic             sat_o
);

  localparam int F = DAT_W - 2;
  // 1.0 in Q2.F has the same bit pattern as 0.5 in Q1.(DAT_W-1)
  localparam logic [DAT_W-1:0] ONE  = DAT_W'(1) << F;
  localparam logic [DAT_W-1:0] YMAX = DAT_W'(sat_max(DAT_W));
  localparam logic [DAT_W-1:0] XMIN = DAT_W'(1) << (DAT_W - 1);
  localparam logic [F:0]       ONET = (F + 1)'(1) << F;

  logic             neg_d, rsat_d;
  logic [DAT_W-1:0] ab, a, am, ry_d;
  logic [F:0]       t_d;

  always_comb begin
    neg_d  = x_i[DAT_W-1];
    ab     = (x_i == XMIN) ? YMAX : (neg_d ? -x_i : x_i);
    a      = (mode_i == ACT_SIGM) ? (ab >> 1) : ab;
    am     = (a >= ONE) ? ONE : a;
    t_d    = (F + 1)'(ONE - am);
    rsat_d = !neg_d && (x_i >= ONE);
    ry_d   = neg_d ? '0 : (rsat_d ? YMAX : (x_i << 1));
  end

  logic [F:0]       t1_q;
  logic             neg1_q, rsat1_q;
  act_mode_e        mode1_q;
  logic [DAT_W-1:0] ry1_q;

  logic [2*F+1:0]   sq;
  logic [F:0]       s_d;

  always_comb begin
    sq  = (2 * F + 2)'(t1_q) * (2 * F + 2)'(t1_q);
    s_d = (F + 1)'(sq >> F);
  end

  logic [F:0]       s2_q;
  logic             neg2_q, rsat2_q;
  act_mode_e        mode2_q;
  logic [DAT_W-1:0] ry2_q;

  logic [F:0]          m;
  logic                msat;
  logic [DAT_W-1:0]    mq, ms, y_d;
  logic signed [DAT_W:0] sg;
  logic                sat_d;

  always_comb begin
    m     = ONET - s2_q;
    msat  = (m == ONET);
    mq    = msat ? YMAX : {m, 1'b0};
    ms    = neg2_q ? -mq : mq;
    sg    = $signed({1'b0, ONE}) + ($signed({ms[DAT_W-1], ms}) >>> 1);
    y_d   = '0;
    sat_d = 1'b0;
    unique case (mode2_q)
      ACT_TANH: begin
        y_d   = ms;
        sat_d = msat;
      end
      ACT_SIGM: begin
        y_d   = (sg > $signed({1'b0, YMAX})) ? YMAX : sg[DAT_W-1:0];
        sat_d = msat;
      end
      ACT_RELU: begin
        y_d   = ry2_q;
        sat_d = rsat2_q;
      end
      default: begin
        y_d   = '0;
        sat_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_q    <= '0;
      neg1_q  <= 1'b0;
      rsat1_q <= 1'b0;
      mode1_q <= ACT_TANH;
      ry1_q   <= '0;
      s2_q    <= '0;
      neg2_q  <= 1'b0;
      rsat2_q <= 1'b0;
      mode2_q <= ACT_TANH;
      ry2_q   <= '0;
      y_o     <= '0;
      sat_o   <= 1'b0;
    end else if (en) begin
      t1_q    <= t_d;
      neg1_q  <= neg_d;
      rsat1_q <= rsat_d;
      mode1_q <= mode_i;
      ry1_q   <= ry_d;
      s2_q    <= s_d;
      neg2_q  <= neg1_q;
      rsat2_q <= rsat1_q;
      mode2_q <= mode1_q;
      ry2_q   <= ry1_q;
      y_o     <= y_d;
      sat_o   <= sat_d;
    end
  end

endmodule

// File: rtl/act_calc_pipe.sv
// Pipelined multi-lane activation unit with valid/ready flow control.
// Owns stage valids, global advance and the saturation event counter.
module act_calc_pipe
  import act_pkg::*;
#(
  parameter int DAT_W = 8,
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*DAT_W-1:0] in_x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*DAT_W-1:0] out_y,
  output logic [LANES-1:0]       out_sat,
  output logic [CNT_W-1:0]       sat_cnt,
  input  logic                   cnt_clr
);

  logic en;
  logic v1_q, v2_q, v3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;
  int               pc;

  assign en        = ~v3_q | out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign sat_cnt   = cnt_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane_core #(.DAT_W(DAT_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .mode_i (act_mode_e'(in_mode)),
      .x_i    (in_x[g*DAT_W +: DAT_W]),
      .y_o    (out_y[g*DAT_W +: DAT_W]),
      .sat_o  (out_sat[g])
    );
  end

  always_comb begin
    pc = 0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + (out_sat[i] ? 1 : 0);
    end
    sum   = {1'b0, cnt_q} + (CNT_W + 1)'(pc);
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (v3_q && out_ready) begin
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (en) begin
        v1_q <= in_valid;
        v2_q <= v1_q;
        v3_q <= v2_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_act_calc_pipe.sv
// Directed bench for act_calc_pipe with DAT_W=8, LANES=2.
// Vector table plus streaming, stall, reset and clear sequences.
module tb_act_calc_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = 2'd0;
  logic [15:0] in_x = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_y;
  logic [1:0]  out_sat;
  logic [15:0] sat_cnt;
  logic        cnt_clr = 1'b0;

  act_calc_pipe #(.DAT_W(8), .LANES(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sat   (out_sat),
    .sat_cnt   (sat_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] x0, x1, y0, y1;
    logic [1:0] sat;
  } vec_t;

  vec_t vt[11];

  logic [1:0]  bm[8];
  logic [15:0] bx[8];
  logic [15:0] by[8];

  // single beat, out_ready held high; returns latency in cycles
  task automatic one_beat(input logic [1:0] md, input logic [15:0] x,
                          output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = md;
    in_x     = x;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_seq(input int n, input bit stall, input string tag);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int extra = 0;
    logic [15:0] held = 16'h0;
    bit hv = 1'b0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      in_valid  = (sent < n);
      if (sent < n) begin
        in_mode = bm[sent];
        in_x    = bx[sent];
      end
      #1;
      if (hv) begin
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_stall_hold"}, 32'(out_y), 32'(held));
      end
      hv   = out_valid && !out_ready;
      held = out_y;
      if (out_valid && out_ready) begin
        chk($sformatf("%s_beat%0d", tag, got), 32'(out_y), 32'(by[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, 32'(got), 32'(n));
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk({tag, "_no_dup"}, 32'(extra), 32'd0);
  endtask

  int lat;
  int exp_cnt;
  int stale;

  initial begin
    vt[0]  = '{2'd0, 8'h20, 8'hE0, 8'h60, 8'hA0, 2'b00};
    vt[1]  = '{2'd0, 8'h40, 8'h80, 8'h7F, 8'h81, 2'b11};
    vt[2]  = '{2'd1, 8'h00, 8'h40, 8'h40, 8'h70, 2'b00};
    vt[3]  = '{2'd2, 8'h20, 8'hF0, 8'h40, 8'h00, 2'b00};
    vt[4]  = '{2'd2, 8'h50, 8'h3F, 8'h7F, 8'h7E, 2'b01};
    vt[5]  = '{2'd3, 8'h40, 8'h80, 8'h00, 8'h00, 2'b00};
    vt[6]  = '{2'd1, 8'hC0, 8'h80, 8'h10, 8'h00, 2'b10};
    vt[7]  = '{2'd0, 8'h10, 8'h00, 8'h38, 8'h00, 2'b00};
    vt[8]  = '{2'd0, 8'h3F, 8'hC1, 8'h7F, 8'h81, 2'b11};
    vt[9]  = '{2'd2, 8'h40, 8'h80, 8'h7F, 8'h00, 2'b01};
    vt[10] = '{2'd1, 8'h7F, 8'h20, 8'h7F, 8'h5C, 2'b01};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    exp_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      one_beat(vt[i].mode, {vt[i].x1, vt[i].x0}, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_y", i), 32'(out_y), 32'({vt[i].y1, vt[i].y0}));
      chk($sformatf("v%0d_sat", i), 32'(out_sat), 32'(vt[i].sat));
      exp_cnt += int'(vt[i].sat[0]) + int'(vt[i].sat[1]);
      @(negedge clk);
      chk($sformatf("v%0d_cnt", i), 32'(sat_cnt), 32'(exp_cnt));
    end

    for (int k = 0; k < 8; k++) begin
      logic [7:0] a0, a1;
      a0 = 8'(k * 4 + 1);
      a1 = 8'(8'h3F - k * 2);
      bm[k] = 2'd2;
      bx[k] = {a1, a0};
      by[k] = {a1 << 1, a0 << 1};
    end
    run_seq(8, 1'b1, "stream");

    for (int k = 0; k < 6; k++) begin
      bm[k] = (k % 2 == 0) ? 2'd0 : 2'd2;
      bx[k] = ((k % 4) < 2) ? 16'hE020 : 16'h4010;
    end
    by[0] = 16'hA060; by[1] = 16'h0040;
    by[2] = 16'h7F38; by[3] = 16'h7F20;
    by[4] = 16'hA060; by[5] = 16'h0040;
    run_seq(6, 1'b0, "alt");

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = 2'd0;
      in_x     = 16'h4040;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(sat_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("mid_no_stale", 32'(stale), 32'd0);

    one_beat(2'd0, 16'h4040, lat);
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("clr_pre_cnt", 32'(sat_cnt), 32'd2);
    one_beat(2'd0, 16'h4040, lat);
    chk("clr_beat_sat", 32'(out_sat), 32'd3);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_wins", 32'(sat_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
